gtx_tx_framer: RTL and testbench

Parametrised transmit framer feeding the GTX transceiver's `txdata`/`txcharisk` inputs in the `txusrclk2` domain. It is the next generation of the fixed 16-bit TX word generator, and adds four things: configurable lane width, a link-up comma burst, periodic comma insertion for receiver alignment, and a valid/ready user interface. It also has a built-in counter test-pattern mode for loopback bring-up.

---
 rtl/gtx_pkg.sv | 52 +++++
 rtl/gtx_tx_pattern.sv | 29 ++
 rtl/gtx_tx_framer.sv | 114 +++++++++++
 tb/tb_gtx_tx_framer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/gtx_pkg.sv
// Shared definitions for the GTX transmit framer: K/D characters, FSM and
// mode enums, and the comma-word builder used for any lane width.
package gtx_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D16_2 = 8'h50;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    USER  = 2'd0,
    COUNT = 2'd1,
    IDLE  = 2'd2
  } tx_mode_t;

  // Widest supported lane (4 bytes); callers slice down to their width.
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] data;
  } tx_word_t;

  // Both mode encodings 2 and 3 mean IDLE.
  function automatic tx_mode_t decode_mode(input logic [1:0] mode);
    case (mode)
      2'd0:    return USER;
      2'd1:    return COUNT;
      default: return IDLE;
    endcase
  endfunction

  // Even bytes carry K28.5 flagged as K, odd bytes carry D16.2.
  function automatic tx_word_t comma_word(input int unsigned bytes);
    tx_word_t w;
    w = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < bytes) begin
        if ((i % 2) == 0) begin
          w.data[8*i +: 8] = K28_5;
          w.ctrl[i]        = 1'b1;
        end else begin
          w.data[8*i +: 8] = D16_2;
        end
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/gtx_tx_pattern.sv
// COUNT-mode pattern generator: presents the current pattern value and
// advances it by one per enabled cycle. A clear makes the presented value 0
// in the same cycle, so the first word after entry is always zero.
module gtx_tx_pattern #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] pat_o
);

  logic [WIDTH-1:0] pat_q;

  assign pat_o = clr_i ? '0 : pat_q;

  // Pattern register: step after an emitted word, hold on forced commas.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pat_q <= '0;
    end else if (clr_i || en_i) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of process ordering.
      pat_q <= pat_o + WIDTH'(en_i);
    end
  end

endmodule

// File: rtl/gtx_tx_framer.sv
// GTX transmit framer: link-up comma burst, periodic comma insertion,
// valid/ready user path and a counter test pattern, one registered word
// per txusrclk2 cycle.
module gtx_tx_framer
  import gtx_pkg::*;
#(
  parameter int unsigned BYTES        = 2,
  parameter int unsigned ALIGN_PERIOD = 256,
  parameter int unsigned ALIGN_BURST  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [1:0]           mode_i,
  input  logic [8*BYTES-1:0]   data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [BYTES-1:0]     ctrl_o,
  output logic [8*BYTES-1:0]   data_o,
  output logic                 aligned_o
);

  localparam int unsigned W       = 8 * BYTES;
  localparam int unsigned RUN_W   = $clog2(ALIGN_PERIOD + 1);
  localparam int unsigned BURST_W = $clog2(ALIGN_BURST + 1);

  localparam tx_word_t         COMMA      = comma_word(BYTES);
  localparam logic [W-1:0]     COMMA_DATA = COMMA.data[W-1:0];
  localparam logic [BYTES-1:0] COMMA_CTRL = COMMA.ctrl[BYTES-1:0];

  tx_state_t            state_q, state_d;
  tx_mode_t             mode, mode_q;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [RUN_W-1:0]     run_cnt_q, run_cnt_d;
  logic                 insert_due;
  logic                 pat_clr, pat_en;
  logic [W-1:0]         pat;
  logic [W-1:0]         word_data;
  logic [BYTES-1:0]     word_ctrl;

  assign mode       = decode_mode(mode_i);
  assign insert_due = (run_cnt_q == RUN_W'(ALIGN_PERIOD));
  assign ready_o    = (state_q == RUN) && (mode == USER) && !insert_due;
  // Entry into COUNT is seen as the mode differing from last cycle's mode.
  assign pat_clr    = (mode == COUNT) && (mode_q != COUNT);

  gtx_tx_pattern #(.WIDTH(W)) u_pattern (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (pat_clr),
    .en_i    (pat_en),
    .pat_o   (pat)
  );

  // Next state, burst/run counters and the word to emit at the next edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    burst_d   = burst_q;
    run_cnt_d = '0;
    pat_en    = 1'b0;
    word_data = COMMA_DATA;
    word_ctrl = COMMA_CTRL;

    case (state_q)
      RESET: begin
        // This comma is the first of the burst; a one-word burst is done.
        burst_d = BURST_W'(1);
        state_d = (ALIGN_BURST == 1) ? RUN : ALIGN;
      end
      ALIGN: begin
        burst_d = burst_q + BURST_W'(1);
        if (burst_d == BURST_W'(ALIGN_BURST)) state_d = RUN;
      end
      RUN: begin
        if (!insert_due) begin
          if (mode == USER && valid_i) begin
            word_data = data_i;
            word_ctrl = '0;
            run_cnt_d = run_cnt_q + RUN_W'(1);
          end else if (mode == COUNT) begin
            word_data = pat;
            word_ctrl = '0;
            run_cnt_d = run_cnt_q + RUN_W'(1);
            pat_en    = 1'b1;
          end
        end
      end
      default: state_d = RESET;
    endcase
  end

  // State, counters and registered GTX outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= RESET;
      mode_q    <= IDLE;
      burst_q   <= '0;
      run_cnt_q <= '0;
      data_o    <= '0;
      ctrl_o    <= '0;
      aligned_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode;
      burst_q   <= burst_d;
      run_cnt_q <= run_cnt_d;
      data_o    <= word_data;
      ctrl_o    <= word_ctrl;
      aligned_o <= (state_q == RUN);
    end
  end

endmodule

// File: tb/tb_gtx_tx_framer.sv
// Directed bench for gtx_tx_framer: a vector table for the 16-bit lane,
// a 32-bit lane sequence, and a maximum-period COUNT run covering pattern wrap.
module tb_gtx_tx_framer;

  localparam logic [15:0] C2    = 16'h50BC;
  localparam logic [1:0]  K2    = 2'b01;
  localparam logic [31:0] C4    = 32'h50BC50BC;
  localparam logic [3:0]  K4    = 4'b0101;
  localparam logic [1:0]  M_USR = 2'd0;
  localparam logic [1:0]  M_CNT = 2'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 16-bit lane, burst 4, period 8
  logic        rst2_n, valid2, ready2, aligned2;
  logic [1:0]  mode2, ctrl2;
  logic [15:0] data2, dout2;

  // 32-bit lane, burst 4, period 8
  logic        rst4_n, valid4, ready4, aligned4;
  logic [1:0]  mode4;
  logic [3:0]  ctrl4;
  logic [31:0] data4, dout4;

  // 16-bit lane, burst 1, maximum period, permanently in COUNT
  logic        rstw_n, validw, readyw, alignedw;
  logic [1:0]  modew, ctrlw;
  logic [15:0] dataw, doutw;
  bit          wrap_done = 1'b0;

  gtx_tx_framer #(.BYTES(2), .ALIGN_PERIOD(8), .ALIGN_BURST(4)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst2_n), .mode_i(mode2), .data_i(data2),
    .valid_i(valid2), .ready_o(ready2), .ctrl_o(ctrl2), .data_o(dout2),
    .aligned_o(aligned2)
  );

  gtx_tx_framer #(.BYTES(4), .ALIGN_PERIOD(8), .ALIGN_BURST(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst4_n), .mode_i(mode4), .data_i(data4),
    .valid_i(valid4), .ready_o(ready4), .ctrl_o(ctrl4), .data_o(dout4),
    .aligned_o(aligned4)
  );

  gtx_tx_framer #(.BYTES(2), .ALIGN_PERIOD(65535), .ALIGN_BURST(1)) u_dutw (
    .clk_i(clk), .rst_n_i(rstw_n), .mode_i(modew), .data_i(dataw),
    .valid_i(validw), .ready_o(readyw), .ctrl_o(ctrlw), .data_o(doutw),
    .aligned_o(alignedw)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_pulse;
    logic [1:0]  mode;
    logic        valid;
    logic [15:0] din;
    logic        exp_ready;
    logic [15:0] exp_data;
    logic [1:0]  exp_ctrl;
    logic        exp_aligned;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rp, input logic [1:0] m, input logic v,
                     input logic [15:0] d, input logic er, input logic [15:0] ed,
                     input logic [1:0] ec, input logic ea);
    vec_t x;
    x = '{rp, m, v, d, er, ed, ec, ea};
    vecs.push_back(x);
  endtask

  // Maximum-period COUNT stream: first RUN word after one comma, then the
  // forced comma after 0000..FFFE, then FFFF followed by the wrap to 0000.
  initial begin : wrap_run
    logic [15:0] prev1, prev2;
    logic [1:0]  prevc1, prevc2;
    bit          found;
    @(posedge rstw_n);
    @(posedge clk); #1;
    check("w burst comma", {alignedw, ctrlw, doutw}, {1'b0, K2, C2});
    @(posedge clk); #1;
    check("w first word", {alignedw, ctrlw, doutw}, {1'b1, 2'b00, 16'h0000});
    prev1 = doutw; prevc1 = ctrlw; prev2 = '0; prevc2 = '0;
    found = 1'b0;
    for (int c = 0; c < 70000; c++) begin
      @(posedge clk); #1;
      if (doutw == 16'hFFFF && ctrlw == 2'b00) begin
        found = 1'b1;
        break;
      end
      prev2 = prev1; prevc2 = prevc1;
      prev1 = doutw; prevc1 = ctrlw;
    end
    check("w reached FFFF", 32'(found), 32'd1);
    check("w comma before FFFF", {prevc1, prev1}, {K2, C2});
    check("w FFFE before comma", {prevc2, prev2}, {2'b00, 16'hFFFE});
    @(posedge clk); #1;
    check("w wrap 0000", {ctrlw, doutw}, {2'b00, 16'h0000});
    @(posedge clk); #1;
    check("w after wrap", {ctrlw, doutw}, {2'b00, 16'h0001});
    wrap_done = 1'b1;
  end

  initial begin : main
    rst2_n = 0; rst4_n = 0; rstw_n = 0;
    mode2 = M_USR; valid2 = 0; data2 = '0;
    mode4 = M_USR; valid4 = 0; data4 = '0;
    modew = M_CNT; validw = 0; dataw = '0;

    // Stage 1: link-up burst with no user data; ready only once RUN.
    for (int i = 0; i < 4; i++) add(0, M_USR, 0, 16'h0, 0, C2, K2, 0);
    add(0, M_USR, 0, 16'h0, 1, C2, K2, 1);
    // Stage 2: continuous valid, comma after every 8 data words.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) add(0, M_USR, 1, 16'hDEAD, 1, 16'hDEAD, 2'b00, 1);
      add(0, M_USR, 1, 16'hDEAD, 0, C2, K2, 1);
    end
    // Stage 3: gap in valid resets the run; a full 8 words follow.
    for (int i = 0; i < 3; i++) add(0, M_USR, 1, 16'hDEAD, 1, 16'hDEAD, 2'b00, 1);
    for (int i = 0; i < 2; i++) add(0, M_USR, 0, 16'hDEAD, 1, C2, K2, 1);
    for (int i = 0; i < 8; i++) add(0, M_USR, 1, 16'hDEAD, 1, 16'hDEAD, 2'b00, 1);
    add(0, M_USR, 1, 16'hDEAD, 0, C2, K2, 1);
    // Stage 4: COUNT ignores valid, holds pattern across the forced comma.
    for (int i = 0; i < 8; i++) add(0, M_CNT, 1, 16'hDEAD, 0, 16'(i), 2'b00, 1);
    add(0, M_CNT, 1, 16'hDEAD, 0, C2, K2, 1);
    for (int i = 8; i < 16; i++) add(0, M_CNT, 0, 16'h0, 0, 16'(i), 2'b00, 1);
    add(0, M_CNT, 0, 16'h0, 0, C2, K2, 1);
    for (int i = 16; i < 19; i++) add(0, M_CNT, 0, 16'h0, 0, 16'(i), 2'b00, 1);
    // Run count carries into USER: only 5 more words before the comma.
    for (int i = 0; i < 5; i++) add(0, M_USR, 1, 16'h1234, 1, 16'h1234, 2'b00, 1);
    add(0, M_USR, 1, 16'h1234, 0, C2, K2, 1);
    // Re-entry into COUNT restarts the pattern at zero.
    add(0, M_CNT, 0, 16'h0, 0, 16'h0000, 2'b00, 1);
    add(0, M_CNT, 0, 16'h0, 0, 16'h0001, 2'b00, 1);
    // IDLE, both encodings.
    add(0, 2'd2, 1, 16'hBEEF, 0, C2, K2, 1);
    add(0, 2'd3, 1, 16'hBEEF, 0, C2, K2, 1);
    add(0, M_USR, 1, 16'hBEEF, 1, 16'hBEEF, 2'b00, 1);
    // Stage 5: asynchronous reset mid-stream repeats the whole burst.
    for (int i = 0; i < 4; i++) add(i == 0, M_USR, 0, 16'h0, 0, C2, K2, 0);
    add(0, M_USR, 0, 16'h0, 1, C2, K2, 1);
    add(0, M_USR, 1, 16'h5A5A, 1, 16'h5A5A, 2'b00, 1);

    #2;
    check("reset outputs", {ready2, aligned2, ctrl2, dout2}, 32'h0);
    @(posedge clk); #1;
    check("reset held over edge", {ready2, aligned2, ctrl2, dout2}, 32'h0);
    check("reset 32b outputs", {ready4, aligned4, ctrl4}, 32'h0);
    check("reset 32b data", dout4, 32'h0);
    #1;
    rst2_n = 1; rstw_n = 1;

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].rst_pulse) begin
        #1 rst2_n = 0;
        #1 check($sformatf("v%0d async reset", i), {ready2, aligned2, ctrl2, dout2}, 32'h0);
        #1 rst2_n = 1;
      end
      mode2  = vecs[i].mode;
      valid2 = vecs[i].valid;
      data2  = vecs[i].din;
      #1 check($sformatf("v%0d ready", i), 32'(ready2), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check($sformatf("v%0d data", i), 32'(dout2), 32'(vecs[i].exp_data));
      check($sformatf("v%0d ctrl", i), 32'(ctrl2), 32'(vecs[i].exp_ctrl));
      check($sformatf("v%0d aligned", i), 32'(aligned2), 32'(vecs[i].exp_aligned));
    end

    // Stage 6: 32-bit lane, valid high from release (ignored during burst).
    check("32b still in reset", {ctrl4, dout4}, 36'h0);
    mode4 = M_USR; valid4 = 1; data4 = 32'hCAFEDEAD;
    rst4_n = 1;
    for (int i = 0; i < 15; i++) begin
      logic        er, ea;
      logic [31:0] ed;
      logic [3:0]  ec;
      if (i < 4)       begin er = 0; ea = 0; ed = C4; ec = K4; end
      else if (i < 12) begin er = 1; ea = 1; ed = 32'hCAFEDEAD; ec = 4'b0000; end
      else if (i == 12) begin er = 0; ea = 1; ed = C4; ec = K4; end
      else             begin er = 1; ea = 1; ed = 32'hCAFEDEAD; ec = 4'b0000; end
      @(negedge clk); #1;
      check($sformatf("b4 w%0d ready", i), 32'(ready4), 32'(er));
      @(posedge clk); #1;
      check($sformatf("b4 w%0d data", i), dout4, ed);
      check($sformatf("b4 w%0d ctrl", i), 32'(ctrl4), 32'(ec));
      check($sformatf("b4 w%0d aligned", i), 32'(aligned4), 32'(ea));
    end

    for (int c = 0; c < 80000 && !wrap_done; c++) @(posedge clk);
    check("wrap run finished", 32'(wrap_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
